snake_ctrl: RTL and testbench
=============================

SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum body segments, range 4..32.
REQ-002 Parameter MOVE_DIV, default 8: frame ticks per snake step, at least 1.
REQ-003 clk  in  1  system clock; all state SHALL be on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 frame_tick  in  1  one-cycle pulse per video frame.
REQ-006 dir_in  in  2  requested direction: 0 up, 1 right, 2 down, 3 left.
REQ-007 dir_valid  in  1  qualifies dir_in for one cycle.
REQ-008 restart  in  1  one-cycle pulse that starts a new game.
REQ-009 food_h / food_v  in  5 / 5  food cell column and row from the food generator.
REQ-010 hpos / vpos  in  10 / 10  current pixel position.
REQ-011 new_food_flag  out  1  request to the food generator to place new food.
REQ-012 snake_loc  out  1  pixel is inside an active body cell.
REQ-013 head_h / head_v  out  5 / 5  head cell.
REQ-014 length  out  6  active segment count.
REQ-015 game_over  out  1  snake is dead.

Function
REQ-016 Grid SHALL be 32 columns by 24 rows of 20 px cells; legal cells are h 0..31 and v 0..23.
REQ-017 snake_loc SHALL be combinational and SHALL be 1 iff, for some segment i < length, hpos > h_i*20, hpos < (h_i+1)*20, vpos > v_i*20 and vpos < (v_i+1)*20, with 10-bit arithmetic.
REQ-018 States SHALL be RUN, MOVE and DEAD.
REQ-019 RUN: each frame_tick SHALL increment step_cnt; when a frame_tick arrives with step_cnt == MOVE_DIV-1, step_cnt SHALL clear and the next state SHALL be MOVE.
REQ-020 A cycle with dir_valid SHALL latch dir_in into pending_dir, except that the exact opposite of cur_dir (the direction used for the last move) SHALL be ignored.
REQ-021 MOVE SHALL last exactly one cycle: cur_dir <= pending_dir, next head = seg0 plus one cell in that direction, and the state returns to RUN unless REQ-024 applies.
REQ-022 eat SHALL be true when the next head equals (food_h, food_v).
REQ-023 On a successful move: seg[i] <= seg[i-1] and seg0 <= next head; if eat, length <= min(length+1, MAX_LEN) and new_food_flag <= 1.
REQ-024 Collision: the next head leaving the grid, or equal to segment 0..length-2 (0..length-1 if eat and length < MAX_LEN), SHALL leave the body unchanged, set game_over=1 and go to DEAD.
REQ-025 new_food_flag SHALL stay high until the cycle after the next frame_tick, then clear.
REQ-026 DEAD SHALL ignore dir_valid and frame_tick; restart in DEAD SHALL reload the reset values; restart in RUN or MOVE SHALL be ignored.
REQ-027 Eat and wall collision on the same move: collision SHALL win, and new_food_flag SHALL not assert.

Reset
REQ-028 rst_n low SHALL immediately force state RUN, seg0=(16,12), seg1=(15,12), seg2=(14,12), length=3, cur_dir=pending_dir=right, step_cnt=0, game_over=0, new_food_flag=0.
REQ-029 Reset asserted during MOVE SHALL discard that move.

Configuration
REQ-030 With SNAKE_WRAP_EN defined, leaving the grid SHALL wrap: h 31->0, 0->31, v 23->0, 0->23, and only self-collision kills.
REQ-031 Without SNAKE_WRAP_EN, leaving the grid SHALL cause game over per REQ-024.

Verification
REQ-032 Reset, MOVE_DIV=8, 8 frame_ticks -> head (17,12), length 3, snake_loc=1 at pixel (350,250).
REQ-033 food=(17,12), one step -> length 4, new_food_flag high until the cycle after the next frame_tick.
REQ-034 dir_valid with dir_in=3 while moving right -> ignored; dir_in=0 then step -> head (16,11).
REQ-035 Drive the head to h=31 heading right, then step -> game_over=1, body frozen; restart -> reset values.
REQ-036 SNAKE_WRAP_EN defined, same stimulus as REQ-035 -> head (0,12), game_over=0.

Source files
------------

// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game controller on a 32x24 grid of 20 px cells.
// Ports: clk, rst_n (async active-low); frame_tick, dir_in/dir_valid, restart,
// food_h/food_v, hpos/vpos in; new_food_flag, snake_loc, head_h/head_v,
// length, game_over out. Define SNAKE_WRAP_EN to make the grid edges wrap.
module snake_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int MOVE_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    input  logic       restart,
    input  logic [4:0] food_h,
    input  logic [4:0] food_v,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic       new_food_flag,
    output logic       snake_loc,
    output logic [4:0] head_h,
    output logic [4:0] head_v,
    output logic [5:0] length,
    output logic       game_over
);
    localparam int CW = $clog2(MOVE_DIV + 1);
    localparam logic [5:0] ML = 6'(MAX_LEN);
    typedef enum logic [1:0] {RUN, MOVE, DEAD} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic [1:0] cur_dir_q, cur_dir_d, pend_q, pend_d;
    logic [4:0] seg_h_q [MAX_LEN];
    logic [4:0] seg_h_d [MAX_LEN];
    logic [4:0] seg_v_q [MAX_LEN];
    logic [4:0] seg_v_d [MAX_LEN];
    logic [5:0] len_q, len_d, lim;
    logic       go_q, go_d, nf_q, nf_d;
    logic [4:0] nh_h, nh_v;
    logic       off, wall, eat, hit;
    // Next head; off flags a step off the grid, nh holds the wrapped cell.
    always_comb begin
        nh_h = seg_h_q[0];
        nh_v = seg_v_q[0];
        off  = 1'b0;
        case (pend_q)
            2'd0: begin
                nh_v = (seg_v_q[0] == 5'd0) ? 5'd23 : seg_v_q[0] - 5'd1;
                off  = seg_v_q[0] == 5'd0;
            end
            2'd1: begin
                nh_h = seg_h_q[0] + 5'd1;
                off  = seg_h_q[0] == 5'd31;
            end
            2'd2: begin
                nh_v = (seg_v_q[0] == 5'd23) ? 5'd0 : seg_v_q[0] + 5'd1;
                off  = seg_v_q[0] == 5'd23;
            end
            default: begin
                nh_h = seg_h_q[0] - 5'd1;
                off  = seg_h_q[0] == 5'd0;
            end
        endcase
    end
`ifdef SNAKE_WRAP_EN
    assign wall = 1'b0;
`else
    assign wall = off;
`endif
    assign eat = (nh_h == food_h) && (nh_v == food_v);
    // The tail vacates its cell on a plain move, but stays put when growing.
    assign lim = (eat && len_q < ML) ? len_q : len_q - 6'd1;
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (6'(i) < lim && seg_h_q[i] == nh_h && seg_v_q[i] == nh_v) hit = 1'b1;
    end
    always_comb begin
        snake_loc = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (6'(i) < len_q
                && hpos > 10'(seg_h_q[i]) * 10'd20 && hpos < (10'(seg_h_q[i]) + 10'd1) * 10'd20
                && vpos > 10'(seg_v_q[i]) * 10'd20 && vpos < (10'(seg_v_q[i]) + 10'd1) * 10'd20)
                snake_loc = 1'b1;
    end
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cur_dir_d = cur_dir_q;
        pend_d    = pend_q;
        seg_h_d   = seg_h_q;
        seg_v_d   = seg_v_q;
        len_d     = len_q;
        go_d      = go_q;
        nf_d      = nf_q & ~frame_tick;
        // Reversing into the neck is ignored; opposite direction differs in bit 1.
        if (dir_valid && state_q != DEAD && dir_in != (cur_dir_q ^ 2'd2)) pend_d = dir_in;
        case (state_q)
            RUN: begin
                if (frame_tick) begin
                    if (step_q == CW'(MOVE_DIV - 1)) begin
                        step_d  = '0;
                        state_d = MOVE;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            MOVE: begin
                cur_dir_d = pend_q;
                if (wall || hit) begin
                    go_d    = 1'b1;
                    state_d = DEAD;
                end else begin
                    state_d = RUN;
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_h_d[i] = seg_h_q[i-1];
                        seg_v_d[i] = seg_v_q[i-1];
                    end
                    seg_h_d[0] = nh_h;
                    seg_v_d[0] = nh_v;
                    if (eat) begin
                        len_d = (len_q < ML) ? len_q + 6'd1 : len_q;
                        nf_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (restart) begin
                    state_d   = RUN;
                    step_d    = '0;
                    cur_dir_d = 2'd1;
                    pend_d    = 2'd1;
                    len_d     = 6'd3;
                    go_d      = 1'b0;
                    nf_d      = 1'b0;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_h_d[i] = 5'(16 - i);
                        seg_v_d[i] = 5'd12;
                    end
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            step_q    <= '0;
            cur_dir_q <= 2'd1;
            pend_q    <= 2'd1;
            len_q     <= 6'd3;
            go_q      <= 1'b0;
            nf_q      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_h_q[i] <= 5'(16 - i);
                seg_v_q[i] <= 5'd12;
            end
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cur_dir_q <= cur_dir_d;
            pend_q    <= pend_d;
            len_q     <= len_d;
            go_q      <= go_d;
            nf_q      <= nf_d;
            seg_h_q   <= seg_h_d;
            seg_v_q   <= seg_v_d;
        end
    end
    assign head_h        = seg_h_q[0];
    assign head_v        = seg_v_q[0];
    assign length        = len_q;
    assign game_over     = go_q;
    assign new_food_flag = nf_q;
endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: directed self-checking bench for snake_ctrl (default parameters).
module tb_snake_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, frame_tick, dir_valid, restart;
    logic [1:0] dir_in;
    logic [4:0] food_h, food_v, head_h, head_v;
    logic [9:0] hpos, vpos;
    logic       new_food_flag, snake_loc, game_over;
    logic [5:0] length;
    int         errs = 0, checks = 0, tk = 0;
    snake_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .dir_in(dir_in),
        .dir_valid(dir_valid), .restart(restart), .food_h(food_h), .food_v(food_v),
        .hpos(hpos), .vpos(vpos), .new_food_flag(new_food_flag), .snake_loc(snake_loc),
        .head_h(head_h), .head_v(head_v), .length(length), .game_over(game_over)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        tk++;
    endtask
    task automatic step();
        repeat (8 - tk) tick();
        tk = 0;
    endtask
    task automatic turn(input logic [1:0] d);
        dir_in = d;
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask
    task automatic pix(input int h, input int v);
        hpos = 10'(h);
        vpos = 10'(v);
        #1;
    endtask
    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; dir_valid = 1'b0; restart = 1'b0;
        dir_in = 2'd1; food_h = 5'd0; food_v = 5'd0; hpos = 10'd330; vpos = 10'd250;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_head_h", head_h, 16);
        chk("rst_head_v", head_v, 12);
        chk("rst_len", length, 3);
        chk("rst_go", game_over, 0);
        chk("rst_nf", new_food_flag, 0);
        chk("rst_loc_head", snake_loc, 1);
        pix(350, 250); chk("rst_loc_ahead", snake_loc, 0);
        pix(320, 250); chk("loc_edge", snake_loc, 0);
        pix(290, 250); chk("rst_loc_tail", snake_loc, 1);
        step();
        chk("step_head_h", head_h, 17);
        chk("step_head_v", head_v, 12);
        chk("step_len", length, 3);
        pix(350, 250); chk("step_loc", snake_loc, 1);
        pix(290, 250); chk("step_loc_tail_gone", snake_loc, 0);
        restart = 1'b1; @(negedge clk); restart = 1'b0;
        chk("restart_run_ignored", head_h, 17);
        food_h = 5'd18; food_v = 5'd12;
        step();
        chk("eat_head_h", head_h, 18);
        chk("eat_len", length, 4);
        chk("eat_nf", new_food_flag, 1);
        food_h = 5'd0; food_v = 5'd0;
        repeat (3) @(negedge clk);
        chk("nf_held", new_food_flag, 1);
        frame_tick = 1'b1;
        #1 chk("nf_during_tick", new_food_flag, 1);
        @(negedge clk); frame_tick = 1'b0;
        chk("nf_cleared", new_food_flag, 0);
        @(negedge clk); tk++;
        turn(2'd3);
        step();
        chk("reverse_ignored_h", head_h, 19);
        chk("reverse_ignored_v", head_v, 12);
        turn(2'd0);
        step();
        chk("up_h", head_h, 19);
        chk("up_v", head_v, 11);
        turn(2'd1);
        repeat (12) step();
        chk("edge_h", head_h, 31);
        chk("edge_v", head_v, 11);
        chk("edge_go", game_over, 0);
        food_h = 5'd0; food_v = 5'd11;
        step();
`ifdef SNAKE_WRAP_EN
        chk("wrap_h", head_h, 0);
        chk("wrap_v", head_v, 11);
        chk("wrap_go", game_over, 0);
        chk("wrap_eat_len", length, 5);
        chk("wrap_eat_nf", new_food_flag, 1);
`else
        chk("wall_go", game_over, 1);
        chk("wall_head_h", head_h, 31);
        chk("wall_len", length, 4);
        chk("wall_eat_nf", new_food_flag, 0);
        repeat (8) tick();
        chk("dead_frozen_h", head_h, 31);
        chk("dead_frozen_v", head_v, 11);
        restart = 1'b1; @(negedge clk); restart = 1'b0;
        chk("restart_h", head_h, 16);
        chk("restart_v", head_v, 12);
        chk("restart_len", length, 3);
        chk("restart_go", game_over, 0);
        tk = 0;
`endif
        #2 rst_n = 1'b0;
        #1 chk("async_rst_h", head_h, 16);
        chk("async_rst_len", length, 3);
        @(negedge clk); rst_n = 1'b1; tk = 0;
        food_h = 5'd17; food_v = 5'd12;
        step();
        chk("grow_len", length, 4);
        food_h = 5'd0; food_v = 5'd0;
        turn(2'd2); step();
        turn(2'd3); step();
        chk("loop_h", head_h, 16);
        chk("loop_v", head_v, 13);
        food_h = 5'd16; food_v = 5'd12;
        turn(2'd0); step();
        chk("tail_hit_go", game_over, 1);
        chk("tail_hit_len", length, 4);
        chk("tail_hit_h", head_h, 16);
        chk("tail_hit_v", head_v, 13);
        chk("tail_hit_nf", new_food_flag, 0);
        pix(330, 270); chk("final_loc", snake_loc, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
